// File: rtl/weighted_sum_stream.sv
// Streaming unsigned dot product of N_CH data lanes against N_CH weight lanes with
// multi-beat accumulation, full-pipeline stall and saturating/truncating output.
module weighted_sum_stream #(
    parameter int N_CH  = 4,
    parameter int DW    = 16,
    parameter int WW    = 16,
    parameter int OW    = 16,
    parameter int SAT   = 1,
    parameter int ACC_W = DW + WW + $clog2(N_CH) + 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_CH*DW-1:0]   in_data,
    input  logic [N_CH*WW-1:0]   in_weights,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OW-1:0]        out_result,
    output logic                 out_ovf
);

    localparam int L  = $clog2(N_CH);
    localparam int PW = DW + WW;
    localparam int SW = PW + L;

    // Level 0 is the product stage; level l holds N_CH>>l partial sums (upper entries unused)
    logic [SW-1:0]    lvl_q [L+1][N_CH];
    logic [L:0]       vld_q;
    logic [L:0]       first_q;
    logic [L:0]       last_q;
    logic [SW-1:0]    prod_s [N_CH];

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [OW-1:0]    out_result_q, out_result_d;
    logic             out_ovf_q, out_ovf_d;

    logic             stall_s;
    logic [ACC_W-1:0] base_s;
    logic [ACC_W:0]   add_s;
    logic [ACC_W-1:0] acc_next_s;
    logic             acc_ovf_next_s;
    logic             res_big_s;
    logic [OW-1:0]    fmt_s;

    assign stall_s    = out_valid_q & ~out_ready;
    assign in_ready   = ~stall_s;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_ovf    = out_ovf_q;

    // Per-lane exact products, zero-extended to the final tree width
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            prod_s[i] = {{L{1'b0}}, PW'(in_data[i*DW +: DW]) * PW'(in_weights[i*WW +: WW])};
        end
    end

    // Product and adder-tree pipeline; every level freezes together on stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            for (int l = 0; l <= L; l++) begin
                for (int j = 0; j < N_CH; j++) begin
                    lvl_q[l][j] <= '0;
                end
            end
        end else if (!stall_s) begin
            vld_q[0]   <= in_valid;
            first_q[0] <= in_first;
            last_q[0]  <= in_last;
            for (int j = 0; j < N_CH; j++) begin
                lvl_q[0][j] <= prod_s[j];
            end
            for (int l = 1; l <= L; l++) begin
                vld_q[l]   <= vld_q[l-1];
                first_q[l] <= first_q[l-1];
                last_q[l]  <= last_q[l-1];
                for (int j = 0; j < N_CH/2; j++) begin
                    lvl_q[l][j] <= (j < (N_CH >> l)) ? lvl_q[l-1][2*j] + lvl_q[l-1][2*j+1] : '0;
                end
                for (int j = N_CH/2; j < N_CH; j++) begin
                    lvl_q[l][j] <= '0;
                end
            end
        end
    end

    // Accumulate the tree output with saturation at the accumulator width, then format
    always_comb begin
        base_s = first_q[L] ? '0 : acc_q;
        add_s  = {1'b0, base_s} + {{(ACC_W + 1 - SW){1'b0}}, lvl_q[L][0]};
        if (add_s[ACC_W]) begin
            acc_next_s     = '1;
            acc_ovf_next_s = 1'b1;
        end else begin
            acc_next_s     = add_s[ACC_W-1:0];
            acc_ovf_next_s = first_q[L] ? 1'b0 : acc_ovf_q;
        end
        res_big_s = |acc_next_s[ACC_W-1:OW];
        if ((SAT != 0) && res_big_s) begin
            fmt_s = '1;
        end else begin
            fmt_s = acc_next_s[OW-1:0];
        end
    end

    // Output-stage next state: hold on stall, publish on last, accumulate otherwise
    always_comb begin
        acc_d        = acc_q;
        acc_ovf_d    = acc_ovf_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_ovf_d    = out_ovf_q;
        if (stall_s) begin
            out_valid_d = out_valid_q;
        end else if (vld_q[L] && last_q[L]) begin
            out_valid_d  = 1'b1;
            out_result_d = fmt_s;
            out_ovf_d    = acc_ovf_next_s | res_big_s;
            acc_d        = '0;
            acc_ovf_d    = 1'b0;
        end else if (vld_q[L]) begin
            out_valid_d = 1'b0;
            acc_d       = acc_next_s;
            acc_ovf_d   = acc_ovf_next_s;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Output-stage registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q        <= '0;
            acc_ovf_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_ovf_q    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_ovf_q    <= acc_ovf_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_weighted_sum_stream.sv
// Bench for weighted_sum_stream: a saturating and a truncating instance share stimulus and
// are checked against a queue-based arithmetic model of the dot-product accumulation.
module tb_weighted_sum_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_first, in_last, out_ready;
    logic [63:0] in_data, in_weights;
    logic        in_ready, out_valid, out_ovf;
    logic        in_ready_t, out_valid_t, out_ovf_t;
    logic [15:0] out_result, out_result_t;

    typedef struct { logic [15:0] rs; logic [15:0] rt; logic ovf; int cyc; } exp_t;
    typedef struct { logic [15:0] rs; logic [15:0] rt; logic ovf; logic ovf_t; logic vt; int cyc; } obs_t;

    localparam longint unsigned ACC_MAX = (64'd1 << 42) - 64'd1;
    localparam logic [63:0] VEC_D = {16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [63:0] VEC_W = {16'd3, 16'd4, 16'd6, 16'd12};
    localparam logic [63:0] ALL_F = 64'hFFFF_FFFF_FFFF_FFFF;

    exp_t            exp_q[$];
    obs_t            obs_q[$];
    exp_t            e;
    obs_t            o;
    longint unsigned m_acc, m_sum;
    bit              m_aovf;
    int              cyc;
    int              n_vec = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    weighted_sum_stream #(.N_CH(4), .DW(16), .WW(16), .OW(16), .SAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_weights(in_weights), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_ovf(out_ovf));

    weighted_sum_stream #(.N_CH(4), .DW(16), .WW(16), .OW(16), .SAT(0)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
        .in_data(in_data), .in_weights(in_weights), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid_t), .out_ready(out_ready), .out_result(out_result_t), .out_ovf(out_ovf_t));

    // Reference model and collector, sampled just before each rising edge
    initial begin
        cyc = 0; m_acc = 0; m_aovf = 1'b0;
        forever begin
            @(negedge clk); #4;
            cyc++;
            if (!rst) begin
                exp_q.delete(); obs_q.delete(); m_acc = 0; m_aovf = 1'b0;
            end else begin
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    o.rs = out_result; o.rt = out_result_t; o.ovf = out_ovf;
                    o.ovf_t = out_ovf_t; o.vt = out_valid_t; o.cyc = cyc;
                    obs_q.push_back(o);
                end
                if (in_valid === 1'b1 && in_ready === 1'b1) begin
                    m_sum = 0;
                    for (int i = 0; i < 4; i++)
                        m_sum += 64'(in_data[i*16 +: 16]) * 64'(in_weights[i*16 +: 16]);
                    if (in_first === 1'b1) begin m_acc = 0; m_aovf = 1'b0; end
                    if (ACC_MAX - m_acc < m_sum) begin m_acc = ACC_MAX; m_aovf = 1'b1; end
                    else m_acc = m_acc + m_sum;
                    if (in_last === 1'b1) begin
                        e.rs  = (m_acc > 64'hFFFF) ? 16'hFFFF : m_acc[15:0];
                        e.rt  = m_acc[15:0];
                        e.ovf = m_aovf | (m_acc > 64'hFFFF);
                        e.cyc = cyc;
                        exp_q.push_back(e);
                        m_acc = 0; m_aovf = 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic [63:0] rand_vec(input int unsigned maxv);
        logic [63:0] v;
        for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'($urandom_range(0, maxv));
        return v;
    endfunction

    // Present one beat from negedge+1 and hold it until it is accepted at a rising edge
    task automatic send(input logic [63:0] d, input logic [63:0] w, input logic f, input logic l,
                        input bit rnd, output int waits);
        waits = 0;
        in_valid = 1'b1; in_data = d; in_weights = w; in_first = f; in_last = l;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        while (in_ready !== 1'b1 && waits < 100) begin
            @(negedge clk); #1;
            waits++;
            if (rnd) begin out_ready = ($urandom_range(0, 3) != 0); #1; end
        end
        n_vec++;
        if (waits >= 100) begin
            n_err++; $display("FAIL send_timeout: in_ready=%b, required 1 within 100 cycles", in_ready);
        end
        @(negedge clk); #1;
    endtask

    task automatic idle(input int k);
        in_valid = 1'b0;
        repeat (k) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
        n_vec++; if (out_result !== 16'd0) begin n_err++; $display("FAIL rst_result: got %h, required 0000", out_result); end
        n_vec++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b, required 0", out_ovf); end
        n_vec++; if (out_valid_t !== 1'b0) begin n_err++; $display("FAIL rst_valid_t: got %b, required 0", out_valid_t); end
        n_vec++; if (out_result_t !== 16'd0) begin n_err++; $display("FAIL rst_result_t: got %h, required 0000", out_result_t); end
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk); #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        n_vec++; if (in_ready_t !== 1'b1) begin n_err++; $display("FAIL rst_in_ready_t: got %b, required 1", in_ready_t); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_valid: got %b, required 0", out_valid); end
    endtask

    task automatic test_single;
        int w;
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b1;
        send(VEC_D, VEC_W, 1'b1, 1'b1, 1'b0, w);
        idle(10);
        n_vec++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_err++; $display("FAIL single_count: got %0d results, required 1", obs_q.size());
        end else begin
            n_vec++;
            if (obs_q[0].rs !== 16'd48 || obs_q[0].rt !== 16'd48 || obs_q[0].ovf !== 1'b0 || obs_q[0].ovf_t !== 1'b0)
                begin n_err++; $display("FAIL single_value: got %0d/%0d ovf %b/%b, required 48/48 ovf 0/0",
                      obs_q[0].rs, obs_q[0].rt, obs_q[0].ovf, obs_q[0].ovf_t); end
            n_vec++;
            if (obs_q[0].cyc - exp_q[0].cyc !== 4) begin
                n_err++; $display("FAIL single_latency: got %0d cycles, required 4", obs_q[0].cyc - exp_q[0].cyc);
            end
        end
    endtask

    task automatic test_stream;
        int w;
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(rand_vec(65535), rand_vec(65535), 1'b1, 1'b1, 1'b0, w);
            n_vec++;
            if (w !== 0) begin n_err++; $display("FAIL stream_in_ready: beat %0d waited %0d cycles, required 0", i, w); end
        end
        idle(12);
        n_vec++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            n_err++; $display("FAIL stream_count: got %0d results, required 8", obs_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_vec++;
                if (obs_q[i].rs !== exp_q[i].rs || obs_q[i].rt !== exp_q[i].rt || obs_q[i].ovf !== exp_q[i].ovf ||
                    obs_q[i].ovf_t !== exp_q[i].ovf || obs_q[i].vt !== 1'b1 || obs_q[i].cyc !== obs_q[0].cyc + i)
                    begin n_err++; $display("FAIL stream_result[%0d]: got %h/%h ovf %b cyc+%0d, required %h/%h ovf %b cyc+%0d",
                          i, obs_q[i].rs, obs_q[i].rt, obs_q[i].ovf, obs_q[i].cyc - obs_q[0].cyc,
                          exp_q[i].rs, exp_q[i].rt, exp_q[i].ovf, i); end
            end
        end
    endtask

    task automatic test_accumulate;
        int w;
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b1;
        send(VEC_D, VEC_W, 1'b1, 1'b0, 1'b0, w);
        send(VEC_D, VEC_W, 1'b0, 1'b0, 1'b0, w);
        send(VEC_D, VEC_W, 1'b0, 1'b1, 1'b0, w);
        idle(10);
        n_vec++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_err++; $display("FAIL acc_count: got %0d results, required 1", obs_q.size());
        end else begin
            n_vec++;
            if (obs_q[0].rs !== 16'd144 || obs_q[0].rt !== 16'd144 || obs_q[0].ovf !== 1'b0)
                begin n_err++; $display("FAIL acc_value: got %0d/%0d ovf %b, required 144/144 ovf 0",
                      obs_q[0].rs, obs_q[0].rt, obs_q[0].ovf); end
            n_vec++;
            if (obs_q[0].cyc - exp_q[0].cyc !== 4) begin
                n_err++; $display("FAIL acc_latency: got %0d cycles after last beat, required 4", obs_q[0].cyc - exp_q[0].cyc);
            end
        end
    endtask

    task automatic test_backpressure;
        int w;
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(rand_vec(255), rand_vec(255), 1'b1, 1'b1, 1'b0, w);
        in_data = rand_vec(255); in_weights = rand_vec(255); in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (in_ready !== 1'b0 || in_ready_t !== 1'b0 || out_valid !== 1'b1 || exp_q.size() == 0 ||
                out_result !== exp_q[0].rs || out_result_t !== exp_q[0].rt)
                begin n_err++; $display("FAIL stall_hold[%0d]: in_ready %b valid %b result %h/%h, required 0 1 %h/%h",
                      c, in_ready, out_valid, out_result, out_result_t,
                      (exp_q.size() > 0) ? exp_q[0].rs : 16'h0, (exp_q.size() > 0) ? exp_q[0].rt : 16'h0); end
            @(negedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release: in_ready %b, required 1", in_ready); end
        @(negedge clk); #1;
        idle(12);
        n_vec++;
        if (obs_q.size() != 5 || exp_q.size() != 5) begin
            n_err++; $display("FAIL bp_count: got %0d results, required 5", obs_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (obs_q[i].rs !== exp_q[i].rs || obs_q[i].rt !== exp_q[i].rt || obs_q[i].ovf !== exp_q[i].ovf)
                    begin n_err++; $display("FAIL bp_result[%0d]: got %h/%h ovf %b, required %h/%h ovf %b",
                          i, obs_q[i].rs, obs_q[i].rt, obs_q[i].ovf, exp_q[i].rs, exp_q[i].rt, exp_q[i].ovf); end
            end
        end
    endtask

    task automatic test_overflow;
        int w;
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b1;
        send(ALL_F, ALL_F, 1'b1, 1'b1, 1'b0, w);
        for (int i = 0; i < 260; i++) send(ALL_F, ALL_F, (i == 0), (i == 259), 1'b0, w);
        send(VEC_D, VEC_W, 1'b1, 1'b1, 1'b0, w);
        idle(10);
        n_vec++;
        if (obs_q.size() != 3) begin
            n_err++; $display("FAIL ovf_count: got %0d results, required 3", obs_q.size());
        end else begin
            n_vec++;
            if (obs_q[0].rs !== 16'hFFFF || obs_q[0].ovf !== 1'b1 || obs_q[0].rt !== 16'h0004 || obs_q[0].ovf_t !== 1'b1)
                begin n_err++; $display("FAIL ovf_single: got %h/%h ovf %b/%b, required ffff/0004 ovf 1/1",
                      obs_q[0].rs, obs_q[0].rt, obs_q[0].ovf, obs_q[0].ovf_t); end
            n_vec++;
            if (obs_q[1].rs !== 16'hFFFF || obs_q[1].ovf !== 1'b1 || obs_q[1].rt !== 16'hFFFF || obs_q[1].ovf_t !== 1'b1)
                begin n_err++; $display("FAIL ovf_acc_sat: got %h/%h ovf %b/%b, required ffff/ffff ovf 1/1",
                      obs_q[1].rs, obs_q[1].rt, obs_q[1].ovf, obs_q[1].ovf_t); end
            n_vec++;
            if (obs_q[2].rs !== 16'd48 || obs_q[2].rt !== 16'd48 || obs_q[2].ovf !== 1'b0 || obs_q[2].ovf_t !== 1'b0)
                begin n_err++; $display("FAIL ovf_cleared: got %0d/%0d ovf %b/%b, required 48/48 ovf 0/0",
                      obs_q[2].rs, obs_q[2].rt, obs_q[2].ovf, obs_q[2].ovf_t); end
        end
    endtask

    task automatic test_reset_mid;
        int w;
        out_ready = 1'b1;
        send(VEC_D, VEC_W, 1'b1, 1'b0, 1'b0, w);
        send(VEC_D, VEC_W, 1'b0, 1'b0, 1'b0, w);
        send(rand_vec(255), rand_vec(255), 1'b0, 1'b1, 1'b0, w);
        in_valid = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_valid_t !== 1'b0 || out_result !== 16'd0 || out_ovf !== 1'b0)
            begin n_err++; $display("FAIL midrst_clear: valid %b/%b result %h ovf %b, required 0/0 0000 0",
                  out_valid, out_valid_t, out_result, out_ovf); end
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        exp_q.delete(); obs_q.delete();
        idle(8);
        n_vec++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL midrst_residue: got %0d results, required 0", obs_q.size()); end
        send(VEC_D, VEC_W, 1'b1, 1'b1, 1'b0, w);
        idle(10);
        n_vec++;
        if (obs_q.size() != 1) begin
            n_err++; $display("FAIL midrst_count: got %0d results, required 1", obs_q.size());
        end else begin
            n_vec++;
            if (obs_q[0].rs !== 16'd48 || obs_q[0].rt !== 16'd48 || obs_q[0].ovf !== 1'b0)
                begin n_err++; $display("FAIL midrst_value: got %0d/%0d ovf %b, required 48/48 ovf 0",
                      obs_q[0].rs, obs_q[0].rt, obs_q[0].ovf); end
        end
    endtask

    task automatic test_random;
        int w, len;
        int unsigned mx;
        exp_q.delete(); obs_q.delete();
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 4);
            mx  = ($urandom_range(0, 3) == 0) ? 65535 : 255;
            for (int b = 0; b < len; b++)
                send(rand_vec(mx), rand_vec(mx), (b == 0), (b == len - 1), 1'b1, w);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        out_ready = 1'b1;
        idle(12);
        n_vec++;
        if (obs_q.size() != 40 || exp_q.size() != 40) begin
            n_err++; $display("FAIL rand_count: got %0d results (model %0d), required 40", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 40; i++) begin
                n_vec++;
                if (obs_q[i].rs !== exp_q[i].rs || obs_q[i].rt !== exp_q[i].rt ||
                    obs_q[i].ovf !== exp_q[i].ovf || obs_q[i].ovf_t !== exp_q[i].ovf || obs_q[i].vt !== 1'b1)
                    begin n_err++; $display("FAIL rand_result[%0d]: got %h/%h ovf %b/%b, required %h/%h ovf %b",
                          i, obs_q[i].rs, obs_q[i].rt, obs_q[i].ovf, obs_q[i].ovf_t,
                          exp_q[i].rs, exp_q[i].rt, exp_q[i].ovf); end
            end
        end
    endtask

    initial begin
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_data = '0; in_weights = '0;
        test_reset();
        test_single();
        test_stream();
        test_accumulate();
        test_backpressure();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/weighted_sum_stream.md
Name: weighted_sum_stream

Overview:
- Parametrised, streaming successor to the fixed 4-input cascaded weighted-summation pipeline.
- Computes an unsigned dot product of N_CH data lanes against N_CH weight lanes, one vector per cycle.
- Has a valid/ready handshake with a full-pipeline stall, and can accumulate across multi-beat vectors (first/last framing).
- Applies selectable saturation to OW bits and reports a per-result overflow flag. The output feeds the seven-segment display driver or a downstream consumer.

Parameters:
- N_CH, 4: lane count; power of two, 2..16. L = log2(N_CH).
- DW, 16: data lane width.
- WW, 16: weight lane width.
- OW, 16: output result width.
- SAT, 1: 1 = clamp to 2^OW-1 on overflow; 0 = truncate to the low OW bits.
- ACC_W, DW+WW+L+8: internal accumulator width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  N_CH*DW  lane i at bits [i*DW +: DW].
- in_weights  in  N_CH*WW  lane i at bits [i*WW +: WW].
- in_first  in  1  beat starts a new accumulation.
- in_last  in  1  beat ends an accumulation; a result is produced.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  OW  weighted sum (saturated or truncated).
- out_ovf  out  1  result exceeded 2^OW-1 or the accumulator overflowed.

Behaviour:
- Reset: while rst=0, all pipeline valids=0, accumulator=0, out_valid=0, out_result=0, out_ovf=0. Reset may assert at any time; beats in flight are discarded with no partial output. in_ready=1 after reset.
- Arithmetic: all unsigned.
  - Stage M registers N_CH products of DW+WW bits.
  - L adder-tree stages each register pairwise sums, growing 1 bit per level. Final sum is DW+WW+L bits, exact.
  - Stage O holds the accumulator and output register.
- Latency: an accepted beat reaches stage O after L+2 cycles when there is no stall (N_CH=4 gives 4 cycles).
- Handshake:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - On stall every stage, including valids and sideband, holds its value.
  - Bubbles propagate as valid=0 and do not disturb the accumulator.
  - out_result and out_ovf are stable while stall=1.
- Sideband: first/last travel with their beat through every stage.
- Stage O on a valid, non-stalled beat:
  - acc_next = (first ? 0 : acc) + sum.
  - If the addition exceeds 2^ACC_W-1, acc_next = 2^ACC_W-1 and a sticky acc_ovf is set. acc_ovf is cleared on first.
  - If last=1: out_valid<=1, out_result<=fmt(acc_next), out_ovf<=acc_ovf | (acc_next > 2^OW-1). The accumulator then clears to 0.
  - If last=0: out_valid<=0 (once the prior result has transferred), accumulator<=acc_next.
- fmt: SAT=1 gives min(acc_next, 2^OW-1); SAT=0 gives acc_next[OW-1:0].
- out_valid clears the cycle after a transfer unless a new last beat arrives in that same cycle. Back-to-back results at one per cycle are sustained.
- Single-beat mode: tie in_first=in_last=1.
- A beat with last=1 and first=0 after a missing first continues the existing accumulator. No error is raised.
- Simultaneous events:
  - A transfer and a new last beat in the same cycle: the new result is loaded and out_valid stays 1.
  - first=1 and last=1 on the same beat: result = sum of that beat only.

Test Plan:
- N_CH=4, single-beat: data {1,2,3,4}, weights {12,6,4,3}, out_ready=1 -> out_result=48, out_ovf=0, out_valid exactly 4 cycles after accept.
- Streaming: 8 consecutive single-beat vectors, out_ready=1 -> 8 results on 8 consecutive cycles, in_ready stays 1.
- Accumulate: 3 beats (first on beat 0, last on beat 2) of the vector above -> one result of 144, out_valid only for beat 2.
- Backpressure: hold out_ready=0 for 5 cycles with a result pending -> in_ready=0, out_result held. Release -> all beats delivered in order, none lost or duplicated.
- Overflow: data all 0xFFFF, weights all 0xFFFF. SAT=1 -> out_result=0xFFFF, out_ovf=1. SAT=0 -> out_result=low 16 bits of 4*0xFFFE0001 = 0x0004, out_ovf=1.
- Reset mid-operation: assert rst=0 with 2 beats in flight and a partial accumulation -> out_valid=0 immediately. After release, a fresh single beat of the first vector yields 48 with no residue.
